lcd_bus_ctrl: RTL

HD44780-style character-LCD bus engine on the DE2 16x2 display. It is the responder side of the host handshake (iDATA/iRS/iStart/oDone) used by the LCD sequencer. It turns each host request into one timed bus cycle on LCD_DATA/LCD_RS/LCD_RW/LCD_EN. Write cycles carry commands and characters. Read cycles return the busy flag/address counter (RS=0) or DDRAM data (RS=1) on oDATA.

---
 rtl/lcd_bus_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style character-LCD bus engine: turns one host request into one timed
// setup / enable / hold bus cycle, writing a byte or reading one back onto oDATA.
module lcd_bus_ctrl #(
   parameter int CLK_DIV = 16
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [7:0] iDATA,
   input  logic       iRS,
   input  logic       iRW,
   input  logic       iStart,
   output logic       oDone,
   output logic [7:0] oDATA,
   inout  wire  [7:0] LCD_DATA,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_RS
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      EN_HIGH = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [7:0] PHASE_TERM = 8'(CLK_DIV - 1);

   state_t     state;
   state_t     nextState;
   logic [7:0] phaseCnt;
   logic [7:0] phaseCntNext;
   logic       startD;
   logic       accept;
   logic       inPhase;
   logic       capture;
   logic [7:0] dataLat;
   logic       rsLat;
   logic       rwLat;
   logic       busOe;
   logic [7:0] busOut;

   assign accept  = iStart && !startD && (state == IDLE);
   assign inPhase = (state == SETUP) || (state == EN_HIGH) || (state == HOLD);
   // EN is still high at the pin on the first HOLD cycle, so sampling here reads mid-strobe
   assign capture = (state == HOLD) && (phaseCnt == 8'd0) && rwLat;

   assign LCD_DATA = busOe ? busOut : 8'bzzzz_zzzz;

   // Next-state and phase-counter logic
   always_comb begin
      nextState    = state;
      phaseCntNext = phaseCnt;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState    = SETUP;
               phaseCntNext = 8'd0;
            end else begin
               nextState    = IDLE;
               phaseCntNext = 8'd0;
            end
         end
         SETUP: begin
            if (phaseCnt == PHASE_TERM) begin
               nextState    = EN_HIGH;
               phaseCntNext = 8'd0;
            end else begin
               phaseCntNext = phaseCnt + 8'd1;
            end
         end
         EN_HIGH: begin
            if (phaseCnt == PHASE_TERM) begin
               nextState    = HOLD;
               phaseCntNext = 8'd0;
            end else begin
               phaseCntNext = phaseCnt + 8'd1;
            end
         end
         HOLD: begin
            if (phaseCnt == PHASE_TERM) begin
               nextState    = DONE;
               phaseCntNext = 8'd0;
            end else begin
               phaseCntNext = phaseCnt + 8'd1;
            end
         end
         DONE: begin
            nextState    = IDLE;
            phaseCntNext = 8'd0;
         end
         default: begin
            nextState    = IDLE;
            phaseCntNext = 8'd0;
         end
      endcase
   end

   // State and phase-counter registers
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= IDLE;
         phaseCnt <= 8'd0;
      end else begin
         state    <= nextState;
         phaseCnt <= phaseCntNext;
      end
   end

   // Start-edge history and transaction latch
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         startD  <= 1'b0;
         dataLat <= 8'h00;
         rsLat   <= 1'b0;
         rwLat   <= 1'b0;
      end else begin
         startD <= iStart;
         if (accept) begin
            dataLat <= iDATA;
            rsLat   <= iRS;
            rwLat   <= iRW;
         end
      end
   end

   // Registered bus and handshake outputs, one cycle behind the state they decode
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         LCD_EN <= 1'b0;
         LCD_RW <= 1'b0;
         LCD_RS <= 1'b0;
         busOe  <= 1'b1;
         busOut <= 8'h00;
         oDone  <= 1'b0;
         oDATA  <= 8'h00;
      end else begin
         LCD_EN <= (state == EN_HIGH);
         LCD_RW <= inPhase && rwLat;
         LCD_RS <= rsLat;
         busOe  <= !(inPhase && rwLat);
         busOut <= dataLat;
         oDone  <= (state == DONE);
         if (capture) begin
            oDATA <= LCD_DATA;
         end
      end
   end

endmodule
